sockit_spi_arb: RTL and testbench
=================================

Name: sockit_spi_arb

Overview:
- Two-requester transaction arbiter in front of the single SPI serializer stream set: command (scw), data write (sdw), data read (sdr).
- Requester X is the XIP engine; requester R is the register/CPU command path.
- Grants whole SPI transactions, not single words, so chip-select framing is never interleaved.
- Routes returned read data to the current owner and releases the grant only after all outstanding reads have drained.

Parameters:
- CDW, 32, command stream word width; bit CDW-1 = EOT (end of transaction), bit CDW-2 = RDX (command produces one sdr word).
- DDW, 32, data write/read stream word width.
- OCW, 4, outstanding-read counter width; at most 2**OCW-1 reads in flight.

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-low.
- x_scw_dat in CDW; x_scw_vld in 1; x_scw_rdy out 1: XIP command stream.
- x_sdw_dat in DDW; x_sdw_vld in 1; x_sdw_rdy out 1: XIP write data.
- x_sdr_dat out DDW; x_sdr_vld out 1; x_sdr_rdy in 1: XIP read data.
- r_scw_*, r_sdw_*, r_sdr_*: same as the x_* set, for the register requester.
- m_scw_dat out CDW; m_scw_vld out 1; m_scw_rdy in 1: command to serializer.
- m_sdw_dat out DDW; m_sdw_vld out 1; m_sdw_rdy in 1: write data to serializer.
- m_sdr_dat in DDW; m_sdr_vld in 1; m_sdr_rdy out 1: read data from serializer.
- own out 2: current owner; 00 none, 01 X, 10 R (status/debug).

Behaviour:
- Handshake on every stream: a transfer occurs when vld & rdy on a rising clk edge. vld must not depend on rdy.
- FSM states: IDLE, GNT_X, GNT_R, DRAIN.
- Reset (rst=0, asynchronous): state IDLE, own=00, outstanding count cnt=0, RR pointer=X. All vld/rdy outputs 0. Data outputs are don't-care, driven 0.
- IDLE: if x_scw_vld, go to GNT_X; else if r_scw_vld, go to GNT_R. Fixed priority, X wins ties. The decision is registered, so the first command passes one cycle after request; nothing passes in IDLE.
- GNT_y muxing:
  - m_scw_* and m_sdw_* connect combinationally to y's streams.
  - The other requester's scw_rdy and sdw_rdy are held 0.
  - m_sdr_* connects to y_sdr_*. The non-owner's sdr_vld is 0.
- Outstanding counter:
  - cnt increments on a command transfer with RDX=1 and decrements on an m_sdr transfer.
  - Simultaneous increment and decrement leave cnt unchanged.
  - When cnt == 2**OCW-1, a command with RDX=1 is stalled: m_scw_vld is gated low and y_scw_rdy is 0. RDX=0 commands still pass.
- EOT handling: on a command transfer with EOT=1, command and write paths close in the same cycle. The next state is IDLE if the updated cnt==0, else DRAIN.
- DRAIN: scw and sdw closed for both requesters; sdr still routed to the owner. When cnt==0 (counting the current-cycle decrement), go to IDLE.
- own: valid from the cycle the grant is registered until leaving DRAIN.
- Read data with cnt==0 (protocol error): accepted and dropped (m_sdr_rdy=1), cnt stays 0. Never routed to a non-owner.
- A requester deasserting vld mid-transaction keeps the grant; there is no timeout.
- Asserting rst mid-transaction aborts immediately. Any in-flight serializer data is the serializer's concern.

Optional Feature:
- Macro: SOCKIT_SPI_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer selects the preferred requester on simultaneous requests. On each IDLE grant the pointer moves to the requester that was not granted.
- Undefined: fixed priority, X over R. No pointer register is present.

Decomposition:
- sockit_spi_pkg holds:
  - typedef own_t, 2-bit enum {OWN_NONE, OWN_X, OWN_R};
  - localparams for the EOT and RDX bit positions;
  - state enum arb_fsm_t.
- One natural sub-module: sockit_spi_arb_cnt, the saturating up/down outstanding-read counter with full/zero flags.

Test Plan:
- X-only transaction: X sends 3 commands, last EOT=1, RDX=1 on cmd 2, serializer returns 0xDEADBEEF two cycles later.
  - own=01 throughout; DRAIN entered; read delivered on x_sdr; IDLE after the read; R never ready.
- Simultaneous request in cycle 0, fixed priority: X granted first. R's transaction starts only after X's EOT plus drain. With RR_EN, a second tie grants R.
- Backpressure: m_scw_rdy held 0 for 5 cycles mid-transaction. Owner stalls, no word lost or duplicated, order preserved.
- Counter full with OCW=2: 3 RDX commands pass and the 4th is stalled. One read returns; the 4th passes in the same cycle as the read's m_sdr transfer or the cycle after, never before.
- Stray read in IDLE: m_sdr_vld=1 with data 0x12345678. Dropped, m_sdr_rdy=1, neither x_sdr_vld nor r_sdr_vld asserted, cnt stays 0.
- Reset in DRAIN with cnt=2: all outputs return to reset values asynchronously; state IDLE and cnt=0 after rst is released.

Source files
------------

// File: rtl/sockit_spi_pkg.sv
// Shared types for the SPI transaction arbiter: owner encoding, FSM states,
// and command-word flag positions (offsets from the command MSB).
package sockit_spi_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_X    = 2'b01,
    OWN_R    = 2'b10
  } own_t;

  typedef enum logic [1:0] {
    IDLE,
    GNT_X,
    GNT_R,
    DRAIN
  } arb_fsm_t;

  // Command word flags, counted down from bit CDW-1.
  localparam int unsigned EOT_OFS = 1;
  localparam int unsigned RDX_OFS = 2;

endpackage

// File: rtl/sockit_spi_arb_cnt.sv
// Saturating up/down counter of outstanding serializer reads, with full/zero
// flags and a look-ahead zero flag for the arbiter's release decision.
module sockit_spi_arb_cnt #(
  parameter int unsigned OCW = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero,
  output logic nxt_zero
);

  logic [OCW-1:0] cnt;
  logic [OCW-1:0] cnt_nxt;

  assign full     = &cnt;
  assign zero     = (cnt == '0);
  assign nxt_zero = (cnt_nxt == '0);

  always_comb begin
    cnt_nxt = cnt;
    if (inc && !dec && !full) begin
      cnt_nxt = cnt + 1'b1;
    end else if (dec && !inc && !zero) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/sockit_spi_arb.sv
// Two-requester (XIP / register) arbiter granting whole SPI transactions.
// Define SOCKIT_SPI_ARB_RR_EN for round-robin tie-breaking instead of X-first.
module sockit_spi_arb
  import sockit_spi_pkg::*;
#(
  parameter int unsigned CDW = 32,
  parameter int unsigned DDW = 32,
  parameter int unsigned OCW = 4
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [CDW-1:0] x_scw_dat,
  input  logic           x_scw_vld,
  output logic           x_scw_rdy,
  input  logic [DDW-1:0] x_sdw_dat,
  input  logic           x_sdw_vld,
  output logic           x_sdw_rdy,
  output logic [DDW-1:0] x_sdr_dat,
  output logic           x_sdr_vld,
  input  logic           x_sdr_rdy,
  input  logic [CDW-1:0] r_scw_dat,
  input  logic           r_scw_vld,
  output logic           r_scw_rdy,
  input  logic [DDW-1:0] r_sdw_dat,
  input  logic           r_sdw_vld,
  output logic           r_sdw_rdy,
  output logic [DDW-1:0] r_sdr_dat,
  output logic           r_sdr_vld,
  input  logic           r_sdr_rdy,
  output logic [CDW-1:0] m_scw_dat,
  output logic           m_scw_vld,
  input  logic           m_scw_rdy,
  output logic [DDW-1:0] m_sdw_dat,
  output logic           m_sdw_vld,
  input  logic           m_sdw_rdy,
  input  logic [DDW-1:0] m_sdr_dat,
  input  logic           m_sdr_vld,
  output logic           m_sdr_rdy,
  output logic [1:0]     own
);

  arb_fsm_t state, state_nxt;
  own_t     own_r, own_nxt;

  logic           sel_x, sel_r, route_x, route_r;
  logic [CDW-1:0] c_dat;
  logic           c_vld, c_rdx, c_eot, stall, cmd_xfer;
  logic           inc, dec, full, zero, nxt_zero;
  logic           x_first;

`ifdef SOCKIT_SPI_ARB_RR_EN
  logic ptr;  // 0: X preferred on a tie, 1: R preferred

  assign x_first = x_scw_vld & (~r_scw_vld | ~ptr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (state == IDLE && (x_scw_vld || r_scw_vld)) begin
      ptr <= x_first;
    end
  end
`else
  assign x_first = x_scw_vld;
`endif

  assign own = own_r;

  always_comb begin
    sel_x = (state == GNT_X);
    sel_r = (state == GNT_R);

    c_dat = sel_x ? x_scw_dat : (sel_r ? r_scw_dat : '0);
    c_vld = (sel_x & x_scw_vld) | (sel_r & r_scw_vld);
    c_rdx = c_dat[CDW-RDX_OFS];
    c_eot = c_dat[CDW-EOT_OFS];
    stall = c_rdx & full;

    m_scw_dat = c_dat;
    m_scw_vld = c_vld & ~stall;
    x_scw_rdy = sel_x & m_scw_rdy & ~stall;
    r_scw_rdy = sel_r & m_scw_rdy & ~stall;
    cmd_xfer  = m_scw_vld & m_scw_rdy;

    m_sdw_dat = sel_x ? x_sdw_dat : (sel_r ? r_sdw_dat : '0);
    m_sdw_vld = (sel_x & x_sdw_vld) | (sel_r & r_sdw_vld);
    x_sdw_rdy = sel_x & m_sdw_rdy;
    r_sdw_rdy = sel_r & m_sdw_rdy;

    // Reads with nothing outstanding are swallowed, never routed to anyone.
    route_x   = (own_r == OWN_X) & ~zero;
    route_r   = (own_r == OWN_R) & ~zero;
    x_sdr_dat = route_x ? m_sdr_dat : '0;
    r_sdr_dat = route_r ? m_sdr_dat : '0;
    x_sdr_vld = route_x & m_sdr_vld;
    r_sdr_vld = route_r & m_sdr_vld;
    m_sdr_rdy = route_x ? x_sdr_rdy : (route_r ? r_sdr_rdy : rst);

    inc = cmd_xfer & c_rdx;
    dec = m_sdr_vld & m_sdr_rdy & ~zero;
  end

  sockit_spi_arb_cnt #(.OCW(OCW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (inc),
    .dec      (dec),
    .full     (full),
    .zero     (zero),
    .nxt_zero (nxt_zero)
  );

  always_comb begin
    state_nxt = state;
    own_nxt   = own_r;
    case (state)
      IDLE: begin
        if (x_first) begin
          state_nxt = GNT_X;
          own_nxt   = OWN_X;
        end else if (r_scw_vld) begin
          state_nxt = GNT_R;
          own_nxt   = OWN_R;
        end
      end
      GNT_X, GNT_R: begin
        if (cmd_xfer && c_eot) begin
          if (nxt_zero) begin
            state_nxt = IDLE;
            own_nxt   = OWN_NONE;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (nxt_zero) begin
          state_nxt = IDLE;
          own_nxt   = OWN_NONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        own_nxt   = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      own_r <= OWN_NONE;
    end else begin
      state <= state_nxt;
      own_r <= own_nxt;
    end
  end

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Self-checking bench for sockit_spi_arb (OCW=2): vector table, directed
// corner sequences and a randomized transaction-level scoreboard.
module tb_sockit_spi_arb;

  localparam int unsigned CDW = 32;
  localparam int unsigned DDW = 32;
  localparam int unsigned OCW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [CDW-1:0] x_scw_dat, r_scw_dat, m_scw_dat;
  logic           x_scw_vld, x_scw_rdy, r_scw_vld, r_scw_rdy, m_scw_vld, m_scw_rdy;
  logic [DDW-1:0] x_sdw_dat, r_sdw_dat, m_sdw_dat;
  logic           x_sdw_vld, x_sdw_rdy, r_sdw_vld, r_sdw_rdy, m_sdw_vld, m_sdw_rdy;
  logic [DDW-1:0] x_sdr_dat, r_sdr_dat, m_sdr_dat;
  logic           x_sdr_vld, x_sdr_rdy, r_sdr_vld, r_sdr_rdy, m_sdr_vld, m_sdr_rdy;
  logic [1:0]     own;

  always #5 clk = ~clk;

  sockit_spi_arb #(.CDW(CDW), .DDW(DDW), .OCW(OCW)) dut (
    .clk(clk), .rst(rst),
    .x_scw_dat(x_scw_dat), .x_scw_vld(x_scw_vld), .x_scw_rdy(x_scw_rdy),
    .x_sdw_dat(x_sdw_dat), .x_sdw_vld(x_sdw_vld), .x_sdw_rdy(x_sdw_rdy),
    .x_sdr_dat(x_sdr_dat), .x_sdr_vld(x_sdr_vld), .x_sdr_rdy(x_sdr_rdy),
    .r_scw_dat(r_scw_dat), .r_scw_vld(r_scw_vld), .r_scw_rdy(r_scw_rdy),
    .r_sdw_dat(r_sdw_dat), .r_sdw_vld(r_sdw_vld), .r_sdw_rdy(r_sdw_rdy),
    .r_sdr_dat(r_sdr_dat), .r_sdr_vld(r_sdr_vld), .r_sdr_rdy(r_sdr_rdy),
    .m_scw_dat(m_scw_dat), .m_scw_vld(m_scw_vld), .m_scw_rdy(m_scw_rdy),
    .m_sdw_dat(m_sdw_dat), .m_sdw_vld(m_sdw_vld), .m_sdw_rdy(m_sdw_rdy),
    .m_sdr_dat(m_sdr_dat), .m_sdr_vld(m_sdr_vld), .m_sdr_rdy(m_sdr_rdy),
    .own(own)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Command word: EOT bit31, RDX bit30, source tag bit16, sequence [15:0].
  function automatic logic [31:0] cmd(input bit eot, input bit rdx, input bit src,
                                      input int unsigned n);
    logic [31:0] w;
    w = '0;
    w[31] = eot;
    w[30] = rdx;
    w[16] = src;
    w[15:0] = n[15:0];
    return w;
  endfunction

  task automatic idle_in();
    x_scw_dat = '0; x_scw_vld = 0; r_scw_dat = '0; r_scw_vld = 0;
    x_sdw_dat = '0; x_sdw_vld = 0; r_sdw_dat = '0; r_sdw_vld = 0;
    x_sdr_rdy = 1;  r_sdr_rdy = 1;
    m_scw_rdy = 1;  m_sdw_rdy = 1;
    m_sdr_vld = 0;  m_sdr_dat = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_in();
    rst = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
  endtask

  typedef struct {
    bit xv, xeot, xrdx, rv, msv;
    bit [31:0] sdat;
    bit [1:0] own;
    bit mcv, xrdy, rrdy, xsv, rsv, msr;
    bit [31:0] xsd;
  } vec_t;

  // Transaction-level reference: per-requester command queues in issue order,
  // and the serializer's pending reads tagged with the requester they belong to.
  typedef struct { bit src; int unsigned due; } rd_t;
  rd_t         rd_q[$];
  logic [31:0] xq[$], rq[$];
  bit          order[$];
  bit          x_keep, r_keep, sdr_keep, vld_always, prev_eot, cur_src;
  int unsigned cyc, scw_mode, bp_lo, bp_hi, xfer_cnt, win_xfers, xsdw_n, rsdw_n;

  task automatic eng_init();
    xq.delete(); rq.delete(); rd_q.delete(); order.delete();
    x_keep = 0; r_keep = 0; sdr_keep = 0; vld_always = 0;
    prev_eot = 1; cur_src = 0;
    cyc = 0; scw_mode = 0; bp_lo = 32'hFFFF_FFFF; bp_hi = 0;
    xfer_cnt = 0; win_xfers = 0; xsdw_n = 0; rsdw_n = 0;
  endtask

  task automatic eng_drive();
    cyc++;
    x_scw_vld = (xq.size() > 0) && (x_keep || vld_always || ($urandom % 3 != 0));
    x_scw_dat = x_scw_vld ? xq[0] : '0;
    x_keep    = x_scw_vld;
    r_scw_vld = (rq.size() > 0) && (r_keep || vld_always || ($urandom % 3 != 0));
    r_scw_dat = r_scw_vld ? rq[0] : '0;
    r_keep    = r_scw_vld;
    if (cyc >= bp_lo && cyc <= bp_hi) m_scw_rdy = 0;
    else m_scw_rdy = (scw_mode == 1) ? 1'b1 : ($urandom % 4 != 0);
    x_sdw_vld = $urandom_range(1, 0) != 0;
    x_sdw_dat = cmd(0, 0, 0, xsdw_n);
    r_sdw_vld = $urandom_range(1, 0) != 0;
    r_sdw_dat = cmd(0, 0, 1, rsdw_n);
    m_sdw_rdy = ($urandom % 3 != 0);
    x_sdr_rdy = ($urandom % 4 != 0);
    r_sdr_rdy = ($urandom % 4 != 0);
    if (!sdr_keep) begin
      if (rd_q.size() > 0 && cyc >= rd_q[0].due) begin
        m_sdr_vld = 1;
        m_sdr_dat = $urandom;
      end else begin
        m_sdr_vld = 0;
      end
    end
    sdr_keep = m_sdr_vld;
  endtask

  task automatic eng_mon();
    bit          sx, sw, dest, src;
    logic [31:0] w, ex;
    // read return: in order, to the requester whose command produced it
    if (m_sdr_vld && rd_q.size() > 0) begin
      dest = rd_q[0].src;
      chk("sdr_x_vld", x_sdr_vld, !dest);
      chk("sdr_r_vld", r_sdr_vld, dest);
      chk("sdr_dat", dest ? r_sdr_dat : x_sdr_dat, m_sdr_dat);
      chk("sdr_rdy", m_sdr_rdy, dest ? r_sdr_rdy : x_sdr_rdy);
      if (m_sdr_rdy) begin
        void'(rd_q.pop_front());
        sdr_keep = 0;
      end
    end else begin
      chk("sdr_none", x_sdr_vld | r_sdr_vld, 0);
    end
    if (rd_q.size() > 0) chk("own_drain", own, rd_q[0].src ? 2 : 1);
    // command stream: whole transactions, per-requester order, read limit
    sx = m_scw_vld & m_scw_rdy;
    chk("x_scw_hs", x_scw_vld & x_scw_rdy, sx & !m_scw_dat[16]);
    chk("r_scw_hs", r_scw_vld & r_scw_rdy, sx & m_scw_dat[16]);
    if (sx) begin
      w   = m_scw_dat;
      src = w[16];
      chk("scw_own", own, src ? 2 : 1);
      if (src) begin
        ex = (rq.size() > 0) ? rq[0] : ~w;
        if (rq.size() > 0) void'(rq.pop_front());
        r_keep = 0;
      end else begin
        ex = (xq.size() > 0) ? xq[0] : ~w;
        if (xq.size() > 0) void'(xq.pop_front());
        x_keep = 0;
      end
      chk("scw_order", w, ex);
      if (!prev_eot) chk("scw_frame", src, cur_src);
      cur_src  = src;
      prev_eot = w[31];
      if (w[30]) begin
        chk("rd_limit", rd_q.size() < 3, 1);
        rd_q.push_back('{src, cyc + 1 + ($urandom % 4)});
      end
      order.push_back(src);
      xfer_cnt++;
      if (cyc >= bp_lo && cyc <= bp_hi) win_xfers++;
    end
    // write data only from the owner, only while granted
    sw = m_sdw_vld & m_sdw_rdy;
    chk("x_sdw_hs", x_sdw_vld & x_sdw_rdy, sw & (own == 2'd1));
    chk("r_sdw_hs", r_sdw_vld & r_sdw_rdy, sw & (own == 2'd2));
    if (sw) begin
      chk("sdw_own", own, m_sdw_dat[16] ? 2 : 1);
      if (m_sdw_dat[16]) rsdw_n++;
      else xsdw_n++;
    end
  endtask

  task automatic run_engine(input int unsigned budget, input string tag);
    int unsigned n;
    n = 0;
    while ((xq.size() + rq.size() + rd_q.size()) > 0 && n < budget) begin
      eng_drive();
      @(negedge clk);
      eng_mon();
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, xq.size() + rq.size() + rd_q.size(), 0);
    idle_in();
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_idle_own"}, own, 0);
    @(posedge clk); #1;
  endtask

  vec_t tv[10];
  bit   p;
  bit   exp_ord[4];

  initial begin
    idle_in();
    // reset values while inputs are active
    x_scw_vld = 1; r_scw_vld = 1; m_sdr_vld = 1; x_sdw_vld = 1;
    @(posedge clk); #2;
    chk("rst_own", own, 0);
    chk("rst_m_scw_vld", m_scw_vld, 0);
    chk("rst_x_scw_rdy", x_scw_rdy, 0);
    chk("rst_r_scw_rdy", r_scw_rdy, 0);
    chk("rst_m_sdw_vld", m_sdw_vld, 0);
    chk("rst_m_sdr_rdy", m_sdr_rdy, 0);
    chk("rst_x_sdr_vld", x_sdr_vld, 0);

    // xv xeot xrdx rv msv sdat | own mcv xrdy rrdy xsv rsv msr xsd
    tv[0] = '{1,0,0,0,0,32'h0,        0,0,0,0,0,0,1,32'h0};
    tv[1] = '{1,0,0,1,0,32'h0,        1,1,1,0,0,0,1,32'h0};
    tv[2] = '{1,0,1,1,0,32'h0,        1,1,1,0,0,0,1,32'h0};
    tv[3] = '{1,1,0,1,0,32'h0,        1,1,1,0,0,0,1,32'h0};
    tv[4] = '{0,0,0,1,1,32'hDEADBEEF, 1,0,0,0,1,0,1,32'hDEADBEEF};
    tv[5] = '{0,0,0,0,0,32'h0,        0,0,0,0,0,0,1,32'h0};
    tv[6] = '{0,0,0,0,1,32'h12345678, 0,0,0,0,0,0,1,32'h0};
    tv[7] = '{1,1,0,0,0,32'h0,        0,0,0,0,0,0,1,32'h0};
    tv[8] = '{1,1,0,0,0,32'h0,        1,1,1,0,0,0,1,32'h0};
    tv[9] = '{0,0,0,0,0,32'h0,        0,0,0,0,0,0,1,32'h0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      x_scw_vld = tv[i].xv;
      x_scw_dat = cmd(tv[i].xeot, tv[i].xrdx, 0, i);
      r_scw_vld = tv[i].rv;
      r_scw_dat = cmd(1, 0, 1, i);
      m_sdr_vld = tv[i].msv;
      m_sdr_dat = tv[i].sdat;
      @(negedge clk);
      chk($sformatf("v%0d_own", i), own, tv[i].own);
      chk($sformatf("v%0d_m_scw_vld", i), m_scw_vld, tv[i].mcv);
      chk($sformatf("v%0d_x_scw_rdy", i), x_scw_rdy, tv[i].xrdy);
      chk($sformatf("v%0d_r_scw_rdy", i), r_scw_rdy, tv[i].rrdy);
      chk($sformatf("v%0d_x_sdr_vld", i), x_sdr_vld, tv[i].xsv);
      chk($sformatf("v%0d_r_sdr_vld", i), r_sdr_vld, tv[i].rsv);
      chk($sformatf("v%0d_m_sdr_rdy", i), m_sdr_rdy, tv[i].msr);
      chk($sformatf("v%0d_x_sdr_dat", i), x_sdr_dat, tv[i].xsd);
      @(posedge clk); #1;
    end
    idle_in();

    // counter full (3 in flight), resume after a read, then reset in DRAIN
    do_reset();
    x_scw_vld = 1;
    x_scw_dat = cmd(0, 1, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      x_scw_dat = cmd(0, 1, 0, i);
      @(negedge clk);
      chk($sformatf("full_pass%0d", i), x_scw_rdy, 1);
      @(posedge clk); #1;
    end
    x_scw_dat = cmd(1, 1, 0, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("full_stall_vld%0d", i), m_scw_vld, 0);
      chk($sformatf("full_stall_rdy%0d", i), x_scw_rdy, 0);
      @(posedge clk); #1;
    end
    m_sdr_vld = 1;
    m_sdr_dat = 32'hA5A5_0001;
    @(negedge clk);
    chk("full_rd_vld", x_sdr_vld, 1);
    chk("full_rd_rdy", m_sdr_rdy, 1);
    p = x_scw_rdy;
    @(posedge clk); #1;
    m_sdr_vld = 0;
    if (p) x_scw_vld = 0;
    @(negedge clk);
    if (!p) chk("full_resume", x_scw_rdy, 1);
    @(posedge clk); #1;
    x_scw_vld = 0;
    m_sdr_vld = 1;
    m_sdr_dat = 32'hA5A5_0002;
    @(negedge clk);
    chk("drain_own", own, 1);
    chk("drain_rd_vld", x_sdr_vld, 1);
    chk("drain_scw_closed", x_scw_rdy | m_scw_vld, 0);
    @(posedge clk); #3;
    rst = 0;
    #1;
    chk("arst_own", own, 0);
    chk("arst_m_sdr_rdy", m_sdr_rdy, 0);
    chk("arst_x_sdr_vld", x_sdr_vld, 0);
    chk("arst_m_scw_vld", m_scw_vld, 0);
    @(negedge clk);
    m_sdr_vld = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("post_rst_own", own, 0);
    chk("post_rst_sdr_rdy", m_sdr_rdy, 1);
    @(posedge clk); #1;
    x_scw_vld = 1;
    x_scw_dat = cmd(1, 0, 0, 7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_grant", x_scw_rdy, 1);
    @(posedge clk); #1;
    x_scw_vld = 0;
    @(negedge clk);
    chk("post_rst_cnt_zero", own, 0);
    @(posedge clk); #1;

    // simultaneous requests: grant order across two ties
    do_reset();
    eng_init();
    vld_always = 1;
    scw_mode   = 1;
    xq.push_back(cmd(1, 1, 0, 0));
    xq.push_back(cmd(1, 0, 0, 1));
    rq.push_back(cmd(1, 0, 1, 0));
    rq.push_back(cmd(1, 0, 1, 1));
`ifdef SOCKIT_SPI_ARB_RR_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 1, 1};
`endif
    run_engine(200, "tie");
    chk("tie_count", order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie_order%0d", i), (i < order.size()) ? order[i] : !exp_ord[i], exp_ord[i]);
    end

    // command backpressure window mid-transaction
    do_reset();
    eng_init();
    vld_always = 1;
    scw_mode   = 1;
    bp_lo      = 3;
    bp_hi      = 7;
    for (int i = 0; i < 5; i++) xq.push_back(cmd(i == 4, i == 1, 0, 16 + i));
    run_engine(300, "bp");
    chk("bp_xfers", xfer_cnt, 5);
    chk("bp_window", win_xfers, 0);

    // randomized transactions from both requesters
    do_reset();
    eng_init();
    for (int s = 0; s < 2; s++) begin
      int unsigned seq;
      seq = 0;
      for (int t = 0; t < 15; t++) begin
        int unsigned len;
        len = $urandom_range(4, 1);
        for (int k = 0; k < len; k++) begin
          if (s == 0) xq.push_back(cmd(k == len - 1, $urandom_range(1, 0) != 0, 0, seq));
          else rq.push_back(cmd(k == len - 1, $urandom_range(1, 0) != 0, 1, seq));
          seq++;
        end
      end
    end
    run_engine(20000, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
